// File: rtl/digit_pkg.sv
// digit_pkg: shared digit/confidence/cost widths and the cost_sequencer state encoding
package digit_pkg;
    localparam int NUM_DIGITS = 10;
    localparam int CONF_W = 4;
    localparam int COST_W = 8;
    typedef enum logic [2:0] {IDLE, LOAD, KICK, WAIT_BUSY, WAIT_DONE, ACCUM, REPORT} cost_seq_state_t;
endpackage

// File: rtl/digit_argmax.sv
// digit_argmax: index of the largest confidence, lowest index wins ties
module digit_argmax
    import digit_pkg::*;
(
    input  logic [0:NUM_DIGITS-1][CONF_W-1:0] conf,
    output logic [3:0]                        idx
);
    logic [CONF_W-1:0] best;
    always_comb begin
        idx = '0;
        best = conf[0];
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (conf[i] > best) begin
                best = conf[i];
                idx = 4'(i);
            end
        end
    end
endmodule

// File: rtl/cost_sequencer.sv
// cost_sequencer: batch controller for cost_calculator; define COST_SEQ_ACCURACY_EN to enable correct_count
module cost_sequencer
    import digit_pkg::*;
#(
    parameter int BATCH_SIZE = 16,
    parameter int ACC_W = 16
) (
    input  logic                              clk,
    input  logic                              n_rst,
    input  logic                              start,
    input  logic                              sample_valid,
    output logic                              sample_ready,
    input  logic [0:NUM_DIGITS-1]             sample_label,
    input  logic [0:NUM_DIGITS-1][CONF_W-1:0] sample_weights,
    output logic                              calc_cost_en,
    output logic [0:NUM_DIGITS-1]             calc_label,
    output logic [0:NUM_DIGITS-1][CONF_W-1:0] calc_weights,
    input  logic                              calc_complete,
    input  logic [COST_W-1:0]                 calc_cost,
    output logic                              batch_busy,
    output logic                              batch_done,
    output logic [ACC_W-1:0]                  batch_cost,
    output logic [7:0]                        sample_index,
    output logic [7:0]                        correct_count
);
    cost_seq_state_t state, next;
    logic [ACC_W:0] sum;
    logic last;
    assign sum = {1'b0, batch_cost} + (ACC_W+1)'(calc_cost);
    assign last = ({1'b0, sample_index} + 9'd1) == 9'(BATCH_SIZE);
    assign sample_ready = state == LOAD;
    assign calc_cost_en = state == KICK;
    assign batch_busy = state != IDLE && state != REPORT;
    assign batch_done = state == REPORT;
    always_ff @(posedge clk) state <= n_rst ? next : IDLE;
    always_comb begin
        next = state;
        case (state)
            IDLE:      next = start ? LOAD : IDLE;
            LOAD:      next = sample_valid ? KICK : LOAD;
            KICK:      next = WAIT_BUSY;
            WAIT_BUSY: next = calc_complete ? WAIT_BUSY : WAIT_DONE;
            WAIT_DONE: next = calc_complete ? ACCUM : WAIT_DONE;
            ACCUM:     next = last ? REPORT : LOAD;
            REPORT:    next = IDLE;
            default:   next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            calc_label <= '0;
            calc_weights <= '0;
            batch_cost <= '0;
            sample_index <= '0;
        end else begin
            if (state == IDLE && start) begin
                batch_cost <= '0;
                sample_index <= '0;
            end
            if (state == LOAD && sample_valid) begin
                calc_label <= sample_label;
                calc_weights <= sample_weights;
            end
            if (state == ACCUM) begin
                batch_cost <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
                sample_index <= sample_index + 8'd1;
            end
        end
    end
`ifdef COST_SEQ_ACCURACY_EN
    logic [3:0] am_idx;
    logic correct;
    digit_argmax u_argmax (.conf(calc_weights), .idx(am_idx));
    // Scored from the holding registers, which still hold this sample during ACCUM
    assign correct = $onehot(calc_label) && calc_label[am_idx];
    always_ff @(posedge clk) begin
        if (!n_rst) correct_count <= '0;
        else if (state == IDLE && start) correct_count <= '0;
        else if (state == ACCUM && correct) correct_count <= correct_count + 8'd1;
    end
`else
    assign correct_count = '0;
`endif
endmodule

// File: doc/cost_sequencer.md
# cost_sequencer

- Batch controller for `cost_calculator`.
- Accepts a stream of samples, each an expected one-hot label plus ten 4-bit digit confidences, over a valid/ready handshake.
- Hands each sample to `cost_calculator` and waits for its completion.
- Accumulates the per-sample costs over a batch of `BATCH_SIZE` samples, then reports the batch total with a one-cycle done pulse.
- Sits between the sample buffer / network output stage and the training/evaluation control logic.

## Interface
Parameters:
- `BATCH_SIZE`, 16: samples per batch, legal range 1..255.
- `ACC_W`, 16: width of the batch cost accumulator.

Ports:
- `clk` in 1: system clock, rising edge.
- `n_rst` in 1: reset, synchronous and active-low.
- `start` in 1: single-cycle request to begin a batch; honoured only in IDLE.
- `sample_valid` in 1: sample present on the `sample_*` inputs.
- `sample_ready` out 1: sequencer can accept a sample.
- `sample_label` in [0:9]: expected label, one-hot.
- `sample_weights` in [0:9][3:0]: digit confidences.
- `calc_cost_en` out 1: start pulse to `cost_calculator`.
- `calc_label` out [0:9]: label to `cost_calculator`.
- `calc_weights` out [0:9][3:0]: confidences to `cost_calculator`.
- `calc_complete` in 1: `calculation_complete` from `cost_calculator`.
- `calc_cost` in 8: `cost_output` from `cost_calculator`.
- `batch_busy` out 1: high from `start` acceptance until `batch_done`.
- `batch_done` out 1: one-cycle pulse; batch results are valid.
- `batch_cost` out ACC_W: saturating sum of sample costs.
- `sample_index` out 8: number of samples completed in the current batch.
- `correct_count` out 8: samples whose argmax equals the label.

## Operation
States:
- IDLE: on `start`, clear `batch_cost`, `sample_index` and `correct_count`, assert `batch_busy`, go to LOAD.
- LOAD: `sample_ready`=1. When `sample_valid` is high, latch label and weights into holding registers, which drive `calc_label`/`calc_weights`, and go to KICK.
- KICK: `calc_cost_en`=1 for exactly one cycle; go to WAIT_BUSY.
- WAIT_BUSY: wait for `calc_complete`=0. `cost_calculator` reports complete while idle, so that level alone is not treated as done. On `calc_complete`=0 go to WAIT_DONE.
- WAIT_DONE: on `calc_complete`=1 go to ACCUM.
- ACCUM:
  - `batch_cost` += zero-extended `calc_cost`, saturating at all-ones.
  - `sample_index` += 1.
  - Update `correct_count`.
  - If `sample_index`+1 == `BATCH_SIZE` go to REPORT, else go to LOAD.
- REPORT: `batch_done`=1 and `batch_busy`=0 for one cycle, then IDLE.

Rules:
- Holding registers are stable from LOAD exit until the next LOAD acceptance, so `calc_label`/`calc_weights` never change while `cost_calculator` is busy.
- Argmax uses the largest `sample_weights` entry; on a tie the lowest index wins.
- A sample is correct when `sample_label` is exactly one-hot and its set bit index equals the argmax. Zero or multi-hot labels count as incorrect, but their cost is still accumulated.
- `start` outside IDLE is ignored.
- `sample_valid` outside LOAD is ignored.
- `batch_cost`, `sample_index` and `correct_count` hold their values after REPORT until the next accepted `start`.

## Timing
Reset values (`n_rst` low at a rising edge):
- State: IDLE.
- All outputs 0: `sample_ready`, `calc_cost_en`, `calc_label`, `calc_weights`, `batch_busy`, `batch_done`, `batch_cost`, `sample_index`, `correct_count`.
- Holding registers are cleared.
- Reset mid-batch abandons the batch without a `batch_done`. `cost_calculator` is reset by the same `n_rst`.

Cycle behaviour:
- `start` at edge N gives `batch_busy`=1 and `sample_ready`=1 from cycle N+1.
- A handshake at edge M gives `calc_cost_en`=1 during cycle M+1.
- Per-sample overhead beyond `cost_calculator` latency is 4 cycles: LOAD, KICK, WAIT_BUSY entry, ACCUM.
- `batch_done` is registered and asserts the cycle after the final ACCUM.
- `BATCH_SIZE`=1 gives exactly one sample then REPORT.

## Configuration
- `COST_SEQ_ACCURACY_EN` defined: argmax and one-hot check are compiled in, and `correct_count` is live.
- Undefined: argmax logic is absent and `correct_count` is constant 0. All other behaviour and timing are identical.

## Structure
- Shared package `digit_pkg` holds:
  - `NUM_DIGITS`=10.
  - `CONF_W`=4.
  - `COST_W`=8.
  - The state enum `cost_seq_state_t` (IDLE, LOAD, KICK, WAIT_BUSY, WAIT_DONE, ACCUM, REPORT).
- One combinational sub-module, `digit_argmax`: inputs `[0:9][3:0]` confidences; outputs a 4-bit index, lowest index on ties. Instantiated only under `COST_SEQ_ACCURACY_EN`.
- `cost_calculator` is instantiated by the parent, not inside this block.

## Test plan
- Reset mid-WAIT_DONE (`n_rst` low 1 cycle) -> next cycle all outputs 0, state IDLE, no `batch_done`.
- `BATCH_SIZE`=2, label 0b0010000000 with weights[2]=15, others 0 -> `calc_cost_en` is a single pulse per sample. A fixed cost 0x05 per sample gives `batch_cost`=10, `correct_count`=2, `batch_done` one cycle.
- Tie: weights[3]=weights[7]=12, label one-hot index 7 -> argmax 3, `correct_count` unchanged.
- `ACC_W`=8, `BATCH_SIZE`=3, cost 0x80 each -> `batch_cost`=0xFF (saturated).
- `sample_valid` toggled low for 5 cycles in LOAD, and `start` pulsed while busy -> sequencer waits with `sample_ready` high; `start` has no effect; final counts are unaffected.
- Build without `COST_SEQ_ACCURACY_EN` -> `correct_count`=0 throughout, `batch_cost` matches the enabled build.
